func_unit_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares a single combinational three-output function unit (a,b,c,d → F1,F2,F3) between two requesters. It accepts a 4-bit operand from the winning requester, drives it onto the shared unit and captures the 3-bit result into a registered response. It then returns the response to the originating port under a valid/ready handshake. It sits between the function unit and its two client blocks. An optional golden checker flags unit mismatches.

---
 rtl/func_unit_arbiter.sv | 152 +++++++++++++++
 tb/tb_func_unit_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/func_unit_arbiter.sv
// Two-port round-robin arbiter and sequencer that time-shares one external combinational
// function unit. Optional golden-model checker is compiled in with `define FU_CHECK_EN.
module func_unit_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_abcd,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_abcd,
    output logic       req1_ready,
    output logic       resp0_valid,
    output logic [2:0] resp0_f,
    input  logic       resp0_ready,
    output logic       resp1_valid,
    output logic [2:0] resp1_f,
    input  logic       resp1_ready,
    output logic [3:0] fu_abcd_o,
    input  logic [2:0] fu_f_i,
    output logic       err_o,
    output logic [7:0] err_cnt,
    output logic [1:0] state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a requester keeps valid and its payload stable until that edge.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [3:0] abcd_q, abcd_d;
    logic [2:0] f0_q, f0_d;
    logic [2:0] f1_q, f1_d;

    logic       any_req;
    logic       gnt;
    logic       accept;
    logic       resp_hs;

    // A tie goes to the port that did not win last time.
    assign any_req    = req0_valid | req1_valid;
    assign gnt        = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    assign req0_ready = (state_q == ST_IDLE) & any_req & ~gnt;
    assign req1_ready = (state_q == ST_IDLE) & any_req & gnt;
    assign accept     = req0_ready | req1_ready;
    assign resp_hs    = (state_q == ST_RESP) & (owner_q ? resp1_ready : resp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            abcd_q  <= 4'd0;
            f0_q    <= 3'd0;
            f1_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            abcd_q  <= abcd_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        abcd_d  = abcd_q;
        f0_d    = f0_q;
        f1_d    = f1_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    abcd_d  = gnt ? req1_abcd : req0_abcd;
                    owner_d = gnt;
                    last_d  = gnt;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (owner_q) begin
                    f1_d = fu_f_i;
                end else begin
                    f0_d = fu_f_i;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp0_valid = (state_q == ST_RESP) & ~owner_q;
    assign resp1_valid = (state_q == ST_RESP) & owner_q;
    assign resp0_f     = f0_q;
    assign resp1_f     = f1_q;
    assign fu_abcd_o   = abcd_q;
    assign state_o     = state_q;

`ifdef FU_CHECK_EN
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] golden;
    logic       ga, gb, gc, gd;

    assign {ga, gb, gc, gd} = abcd_q;
    assign golden[2] = (gb & ~gc) | (~ga & gb & ~gd) | (ga & ~gb & gc & gd);
    assign golden[1] = (~ga & ~gb & gc) | (~ga & gc & ~gd) | (ga & ~gc & gd) | (~gb & gc & ~gd);
    assign golden[0] = (~ga & ~gb & gd) | (~ga & ~gc & gd) | (ga & ~gb & ~gd) | (ga & ~gc & ~gd)
                     | (ga & gb & gc & gd);

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if ((state_q == ST_EVAL) && (fu_f_i != golden)) begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_o   = err_q;
    assign err_cnt = cnt_q;
`else
    assign err_o   = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_func_unit_arbiter.sv
// Directed bench for func_unit_arbiter: models the shared function unit as a lookup
// table and checks arbitration, timing, backpressure, reset and the optional checker.
module tb_func_unit_arbiter;

`ifdef FU_CHECK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_abcd, req1_abcd;
    logic       resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [2:0] resp0_f, resp1_f;
    logic [3:0] fu_abcd_o;
    logic [2:0] fu_f_i;
    logic       err_o;
    logic [7:0] err_cnt;
    logic [1:0] state_o;
    logic       force_en;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    func_unit_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_abcd(req0_abcd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_abcd(req1_abcd), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_f(resp0_f), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_f(resp1_f), .resp1_ready(resp1_ready),
        .fu_abcd_o(fu_abcd_o), .fu_f_i(fu_f_i),
        .err_o(err_o), .err_cnt(err_cnt), .state_o(state_o)
    );

    // Hand-tabulated truth table of the shared unit, {F1,F2,F3} per abcd.
    function automatic logic [2:0] fu_ref(input logic [3:0] x);
        case (x)
            4'd0: return 3'b000;  4'd1: return 3'b001;  4'd2: return 3'b010;  4'd3: return 3'b011;
            4'd4: return 3'b100;  4'd5: return 3'b101;  4'd6: return 3'b110;  4'd7: return 3'b000;
            4'd8: return 3'b001;  4'd9: return 3'b010;  4'd10: return 3'b011; 4'd11: return 3'b100;
            4'd12: return 3'b101; 4'd13: return 3'b110; 4'd14: return 3'b000; default: return 3'b001;
        endcase
    endfunction

    assign fu_f_i = force_en ? 3'b111 : fu_ref(fu_abcd_o);

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every response handshake must match the oldest expected {port,f}
    task automatic sb_pop(input logic p, input logic [2:0] f);
        logic [3:0] e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_unexpected observed=%0h expected=none", {p, f});
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_resp", {4'd0, p, f}, {4'd0, e});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (resp0_valid && resp0_ready) sb_pop(1'b0, resp0_f);
            if (resp1_valid && resp1_ready) sb_pop(1'b1, resp1_f);
        end
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_abcd = 4'd0;  req1_abcd = 4'd0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        force_en = 1'b0;
        cyc();
        cyc();
        chk("rst_state", {6'd0, state_o}, 8'd0);
        chk("rst_fu_abcd", {4'd0, fu_abcd_o}, 8'd0);
        chk("rst_resp0_valid", {7'd0, resp0_valid}, 8'd0);
        chk("rst_resp1_valid", {7'd0, resp1_valid}, 8'd0);
        chk("rst_resp0_f", {5'd0, resp0_f}, 8'd0);
        chk("rst_resp1_f", {5'd0, resp1_f}, 8'd0);
        chk("rst_err_o", {7'd0, err_o}, 8'd0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        rst = 1'b0;

        // single request on port 0
        req0_valid = 1'b1; req0_abcd = 4'b0100;
        #1;
        chk("t1_ready0", {7'd0, req0_ready}, 8'd1);
        chk("t1_ready1", {7'd0, req1_ready}, 8'd0);
        exp_q.push_back({1'b0, 3'b100});
        cyc();
        req0_valid = 1'b0;
        chk("t1_fu_abcd", {4'd0, fu_abcd_o}, 8'h04);
        chk("t1_state_eval", {6'd0, state_o}, 8'd1);
        chk("t1_resp0_early", {7'd0, resp0_valid}, 8'd0);
        cyc();
        chk("t1_resp0_valid", {7'd0, resp0_valid}, 8'd1);
        chk("t1_resp0_f", {5'd0, resp0_f}, 8'h04);
        chk("t1_resp1_valid", {7'd0, resp1_valid}, 8'd0);
        resp0_ready = 1'b1;
        cyc();
        resp0_ready = 1'b0;
        chk("t1_resp0_done", {7'd0, resp0_valid}, 8'd0);
        chk("t1_idle", {6'd0, state_o}, 8'd0);
        chk("t1_resp0_f_hold", {5'd0, resp0_f}, 8'h04);
        chk("t1_fu_abcd_hold", {4'd0, fu_abcd_o}, 8'h04);

        // tie after reset: port 0 first, then port 1 exactly 3 cycles later
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req0_valid = 1'b1; req0_abcd = 4'b0010;
        req1_valid = 1'b1; req1_abcd = 4'b1111;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        #1;
        chk("t2_ready0", {7'd0, req0_ready}, 8'd1);
        chk("t2_ready1", {7'd0, req1_ready}, 8'd0);
        exp_q.push_back({1'b0, 3'b010});
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("t2_ready1_eval", {7'd0, req1_ready}, 8'd0);
        cyc();
        chk("t2_resp0_valid", {7'd0, resp0_valid}, 8'd1);
        chk("t2_resp0_f", {5'd0, resp0_f}, 8'h02);
        chk("t2_ready1_resp", {7'd0, req1_ready}, 8'd0);
        cyc();
        chk("t2_ready1_go", {7'd0, req1_ready}, 8'd1);
        exp_q.push_back({1'b1, 3'b001});
        cyc();
        req1_valid = 1'b0;
        cyc();
        chk("t2_resp1_valid", {7'd0, resp1_valid}, 8'd1);
        chk("t2_resp1_f", {5'd0, resp1_f}, 8'h01);
        chk("t2_resp0_quiet", {7'd0, resp0_valid}, 8'd0);
        chk("t2_resp0_f_hold", {5'd0, resp0_f}, 8'h02);
        cyc();
        chk("t2_idle", {6'd0, state_o}, 8'd0);

        // both ports continuously valid: grants alternate 0,1,0,1,0,1
        req0_valid = 1'b1; req0_abcd = 4'b0100;
        req1_valid = 1'b1; req1_abcd = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t3_ready0", {7'd0, req0_ready}, (i % 2 == 0) ? 8'd1 : 8'd0);
            chk("t3_ready1", {7'd0, req1_ready}, (i % 2 == 1) ? 8'd1 : 8'd0);
            exp_q.push_back((i % 2 == 1) ? {1'b1, 3'b010} : {1'b0, 3'b100});
            cyc();
            cyc();
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // all 16 operands, alternating ports; good unit must never trip the checker
        for (int x = 0; x < 16; x++) begin
            if (x % 2 == 1) begin
                req1_valid = 1'b1; req1_abcd = 4'(x);
            end else begin
                req0_valid = 1'b1; req0_abcd = 4'(x);
            end
            #1;
            chk("sweep_ready", {7'd0, (x % 2 == 1) ? req1_ready : req0_ready}, 8'd1);
            exp_q.push_back({1'(x % 2), 3'(x % 7)});
            cyc();
            req0_valid = 1'b0; req1_valid = 1'b0;
            cyc();
            cyc();
        end
        chk("sweep_err_o", {7'd0, err_o}, 8'd0);
        chk("sweep_err_cnt", err_cnt, 8'd0);

        // backpressure on port 1 while port 0 waits
        resp1_ready = 1'b0;
        req1_valid = 1'b1; req1_abcd = 4'b0001;
        #1;
        chk("t4_ready1", {7'd0, req1_ready}, 8'd1);
        exp_q.push_back({1'b1, 3'b001});
        cyc();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_abcd = 4'b0100;
        #1;
        chk("t4_ready0_eval", {7'd0, req0_ready}, 8'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", {7'd0, resp1_valid}, 8'd1);
            chk("t4_hold_f", {5'd0, resp1_f}, 8'h01);
            chk("t4_hold_ready0", {7'd0, req0_ready}, 8'd0);
            cyc();
        end
        resp1_ready = 1'b1;
        #1;
        chk("t4_hs_valid", {7'd0, resp1_valid}, 8'd1);
        chk("t4_hs_ready0", {7'd0, req0_ready}, 8'd0);
        cyc();
        chk("t4_after_valid", {7'd0, resp1_valid}, 8'd0);
        chk("t4_after_ready0", {7'd0, req0_ready}, 8'd1);
        exp_q.push_back({1'b0, 3'b100});
        cyc();
        req0_valid = 1'b0;
        cyc();
        chk("t4_resp0_valid", {7'd0, resp0_valid}, 8'd1);
        chk("t4_resp0_f", {5'd0, resp0_f}, 8'h04);
        cyc();
        chk("t4_idle", {6'd0, state_o}, 8'd0);

        // reset during EVAL drops the operation
        resp0_ready = 1'b0;
        req0_valid = 1'b1; req0_abcd = 4'b1011;
        #1;
        chk("t5_ready0", {7'd0, req0_ready}, 8'd1);
        cyc();
        req0_valid = 1'b0;
        chk("t5_state_eval", {6'd0, state_o}, 8'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_state", {6'd0, state_o}, 8'd0);
        chk("t5_fu_abcd", {4'd0, fu_abcd_o}, 8'd0);
        chk("t5_resp0_valid", {7'd0, resp0_valid}, 8'd0);
        chk("t5_resp1_valid", {7'd0, resp1_valid}, 8'd0);
        chk("t5_resp0_f", {5'd0, resp0_f}, 8'd0);
        chk("t5_resp1_f", {5'd0, resp1_f}, 8'd0);
        chk("t5_err_o", {7'd0, err_o}, 8'd0);
        chk("t5_err_cnt", err_cnt, 8'd0);
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        cyc();
        chk("t5_no_resp_a", {7'd0, resp0_valid}, 8'd0);
        cyc();
        chk("t5_no_resp_b", {7'd0, resp0_valid}, 8'd0);
        chk("t5_idle", {6'd0, state_o}, 8'd0);

        // faulty unit: 111 for operand 1011 (golden 100), 300 times
        force_en = 1'b1;
        req0_valid = 1'b1; req0_abcd = 4'b1011;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back({1'b0, 3'b111});
            cyc();
            cyc();
            chk("t6_resp0_f", {5'd0, resp0_f}, 8'h07);
            if (i == 0) begin
                chk("t6_err_o_first", {7'd0, err_o}, CHK_ON ? 8'd1 : 8'd0);
                chk("t6_err_cnt_first", err_cnt, CHK_ON ? 8'd1 : 8'd0);
            end
            cyc();
        end
        req0_valid = 1'b0;
        force_en = 1'b0;
        cyc();
        chk("t6_err_o_sat", {7'd0, err_o}, CHK_ON ? 8'd1 : 8'd0);
        chk("t6_err_cnt_sat", err_cnt, CHK_ON ? 8'd255 : 8'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_err_o_clr", {7'd0, err_o}, 8'd0);
        chk("t6_err_cnt_clr", err_cnt, 8'd0);

        chk("sb_drained", 8'(exp_q.size()), 8'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
